// File: rtl/if_stage_ifid_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
package if_stage_ifid_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] PC_INC        = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

endpackage

// File: rtl/if_stage_ifid_ifid.sv
// IF/ID pipeline register: {instr, pc4, valid} with load, bubble and implicit hold.
module ifid_reg
  import if_stage_ifid_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  ifid_t ifid_q;
  ifid_t ifid_d;

  // A bubble keeps pc4 so ID still sees the last sequential address.
  always_comb begin
    ifid_d = ifid_q;
    if (bubble_i) begin
      ifid_d.instr = NOP_INSTR;
      ifid_d.valid = 1'b0;
    end else if (load_i) begin
      ifid_d.instr = instr_i;
      ifid_d.pc4   = pc4_i;
      ifid_d.valid = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_q.instr <= NOP_INSTR;
      ifid_q.pc4   <= 32'd0;
      ifid_q.valid <= 1'b0;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign instr_o = ifid_q.instr;
  assign pc4_o   = ifid_q.pc4;
  assign valid_o = ifid_q.valid;

endmodule

// File: rtl/if_stage_ifid.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory,
// parks a word while ID stalls and discards an in-flight fetch after a redirect.
module if_stage_ifid
  import if_stage_ifid_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  skid_instr_q, skid_instr_d;
  logic [31:0]  skid_pc4_q, skid_pc4_d;
  logic [31:0]  pending_q, pending_d;

  logic         redir;
  logic [31:0]  redir_tgt;
  logic [31:0]  pc_plus4;
  logic         ifid_load;
  logic         ifid_bubble;
  logic [31:0]  ifid_instr_in;
  logic [31:0]  ifid_pc4_in;

  // Branch operands may not be forwarded yet while stalled, so redirects wait.
  assign redir     = (branch_taken | jump) & id_valid & ~stall;
  assign redir_tgt = jump ? jump_target : branch_target;
  assign pc_plus4  = pc_q + PC_INC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      skid_instr_q <= 32'd0;
      skid_pc4_q   <= 32'd0;
      pending_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      pending_q    <= pending_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (redir && !imem_ready)
          state_d = DISCARD;
        else if (!redir && stall && imem_ready)
          state_d = HOLD;
      end
      HOLD:    if (!stall) state_d = FETCH;
      DISCARD: if (imem_ready) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    imem_req      = 1'b1;
    pc_d          = pc_q;
    skid_instr_d  = skid_instr_q;
    skid_pc4_d    = skid_pc4_q;
    pending_d     = pending_q;
    ifid_load     = 1'b0;
    ifid_bubble   = 1'b0;
    ifid_instr_in = imem_rdata;
    ifid_pc4_in   = pc_plus4;
    case (state_q)
      FETCH: begin
        if (redir) begin
          ifid_bubble = 1'b1;
          if (imem_ready) pc_d = redir_tgt;
          else            pending_d = redir_tgt;
        end else if (stall) begin
          if (imem_ready) begin
            skid_instr_d = imem_rdata;
            skid_pc4_d   = pc_plus4;
          end
        end else if (imem_ready) begin
          ifid_load = 1'b1;
          pc_d      = pc_plus4;
        end else begin
          ifid_bubble = 1'b1;
        end
      end
      HOLD: begin
        imem_req = 1'b0;
        if (!stall) begin
          if (redir) begin
            ifid_bubble = 1'b1;
            pc_d        = redir_tgt;
          end else begin
            ifid_load     = 1'b1;
            ifid_instr_in = skid_instr_q;
            ifid_pc4_in   = skid_pc4_q;
            pc_d          = pc_plus4;
          end
        end
      end
      DISCARD: begin
        // The returned word belongs to the abandoned path; only the newest target survives.
        if (redir) pending_d = redir_tgt;
        if (imem_ready) pc_d = redir ? redir_tgt : pending_q;
        if (!stall) ifid_bubble = 1'b1;
      end
      default: imem_req = 1'b1;
    endcase
  end

  ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .instr_i  (ifid_instr_in),
    .pc4_i    (ifid_pc4_in),
    .instr_o  (id_instr),
    .pc4_o    (id_pc4),
    .valid_o  (id_valid)
  );

  assign pc        = pc_q;
  assign imem_addr = pc_q;

endmodule
